// File: rtl/uart_tx.sv
// UART transmitter: 4-deep byte FIFO feeding an 8N1 / 8P1 serialiser with cts_n gating.
// tx, busy and tx_irq are registered; handshake-to-start-bit latency is 2 cycles.

module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  // Extra MSB on each pointer separates full from empty when the low bits match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en && !full)
        wptr <= wptr + PTR_ONE;
      if (rd_en && !empty)
        rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full)
      mem[wptr[AW-1:0]] <= wr_data;
  end
endmodule

module uart_tx #(
  parameter int DIV   = 16,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       cts_n,
  output logic       tx,
  output logic       busy,
  output logic       tx_irq
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_en_q;
  logic          par_bit;

  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic          last;
  logic          start_frame;
  logic          tx_next;

  uart_tx_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (start_frame),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign in_ready = !fifo_full;

  always_comb begin
    last        = (cnt == CNT_LAST);
    // cts_n and the parity config only matter at the frame boundary.
    start_frame = !fifo_empty && !cts_n &&
                  ((state == S_IDLE) || ((state == S_STOP) && last));
    tx_next     = 1'b1;
    case (state)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shreg[0];
      S_PARITY: tx_next = par_bit;
      default:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_irq   <= 1'b0;
    end else begin
      tx     <= tx_next;
      busy   <= (state != S_IDLE);
      tx_irq <= (state == S_STOP) && last;

      if (state != S_IDLE)
        cnt <= last ? '0 : cnt + CNT_ONE;

      if (start_frame) begin
        state    <= S_START;
        shreg    <= fifo_dout;
        par_en_q <= parity_en;
        par_bit  <= (^fifo_dout) ^ parity_odd;
        cnt      <= '0;
        bitcnt   <= '0;
      end else if (last) begin
        case (state)
          S_START: state <= S_DATA;
          S_DATA: begin
            shreg  <= {1'b0, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7)
              state <= par_en_q ? S_PARITY : S_STOP;
          end
          S_PARITY: state <= S_STOP;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: expected bytes queued on push, a line monitor decodes tx frames.
module tb_uart_tx;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       parity_en;
  logic       parity_odd;
  logic       cts_n;
  logic       tx;
  logic       busy;
  logic       tx_irq;

  always #5 clk = ~clk;

  uart_tx #(.DIV(DIV), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .cts_n      (cts_n),
    .tx         (tx),
    .busy       (busy),
    .tx_irq     (tx_irq)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       po;
  } exp_t;

  exp_t sb[$];
  int   starts[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   irq_cnt  = 0;
  bit   mon_on   = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_irq === 1'b1) irq_cnt <= irq_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Samples one bit period starting at the current negedge.
  task automatic get_bit(output logic v, output logic [DIV-1:0] irqv);
    logic st;
    st      = 1'b1;
    v       = tx;
    irqv    = '0;
    irqv[0] = tx_irq;
    for (int k = 1; k < DIV; k++) begin
      @(negedge clk);
      if (!mon_on) return;
      if (tx !== v) st = 1'b0;
      irqv[k] = tx_irq;
    end
    check_eq("bit_stable", st, 1);
  endtask

  task automatic decode_frame();
    exp_t           e;
    logic           v;
    logic [7:0]     d;
    logic [DIV-1:0] irqv;
    logic [DIV-1:0] irq_exp;
    int             t0;
    int             nbits;
    t0 = cyc;
    starts.push_back(t0);
    check_eq("busy_rise", busy, 1);
    if (sb.size() == 0) begin
      check_eq("sb_nonempty", sb.size(), 1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    get_bit(v, irqv);
    if (!mon_on) return;
    check_eq("start_bit", v, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      get_bit(v, irqv);
      if (!mon_on) return;
      d[i] = v;
    end
    check_eq("data", d, e.data);
    if (e.pe) begin
      @(negedge clk);
      get_bit(v, irqv);
      if (!mon_on) return;
      check_eq("parity", v, (^e.data) ^ e.po);
    end
    @(negedge clk);
    get_bit(v, irqv);
    if (!mon_on) return;
    check_eq("stop_bit", v, 1);
    irq_exp = '0;
    irq_exp[DIV-1] = 1'b1;
    check_eq("irq_pos", irqv, irq_exp);
    nbits = e.pe ? 11 : 10;
    check_eq("frame_len", cyc - t0 + 1, nbits * DIV);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (mon_on && tx === 1'b0) begin
        decode_frame();
        @(negedge clk);
        if (mon_on && tx === 1'b1) check_eq("busy_fall", busy, 0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_byte(input logic [7:0] d, input bit add, input bit pe);
    int   g;
    exp_t e;
    g        = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check_eq("push_timeout", g < 2000, 1);
    e.data = d;
    e.pe   = pe;
    e.po   = parity_odd;
    if (add) sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check_eq("idle_timeout", g < 3000, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic start_latency(output int lat);
    lat = 0;
    while (tx !== 1'b0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_active(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) cnt++;
    end
  endtask

  initial begin
    int lat;
    int i0;
    int s0;
    int act;
    rst        = 1'b1;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    cts_n      = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_irq", tx_irq, 0);
    check_eq("rst_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // 0xA5 with even parity, plus first-byte latency
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    i0 = irq_cnt;
    push_byte(8'hA5, 1'b1, 1'b1);
    start_latency(lat);
    check_eq("latency", lat, 2);
    wait_idle();
    check_eq("irq_a5", irq_cnt - i0, 1);

    // parity variants on 0x01
    i0 = irq_cnt;
    parity_odd = 1'b1;
    push_byte(8'h01, 1'b1, 1'b1);
    wait_idle();
    parity_odd = 1'b0;
    push_byte(8'h01, 1'b1, 1'b1);
    wait_idle();
    parity_en = 1'b0;
    push_byte(8'h01, 1'b1, 1'b0);
    wait_idle();
    check_eq("irq_par", irq_cnt - i0, 3);

    // FIFO buffering, back-to-back frames
    i0 = irq_cnt;
    s0 = starts.size();
    for (int i = 0; i < 5; i++) push_byte(8'(17 * (i + 1)), 1'b1, 1'b0);
    check_eq("full_ready", in_ready, 0);
    wait_idle();
    check_eq("stream_frames", starts.size() - s0, 5);
    for (int k = 1; k < 5; k++)
      if (starts.size() > s0 + k)
        check_eq("stream_gap", starts[s0+k] - starts[s0+k-1], 10 * DIV);
    check_eq("irq_stream", irq_cnt - i0, 5);
    check_eq("ready_back", in_ready, 1);

    // flow control
    i0 = irq_cnt;
    cts_n = 1'b1;
    push_byte(8'h3C, 1'b1, 1'b0);
    count_active(100, act);
    check_eq("cts_hold", act, 0);
    cts_n = 1'b0;
    start_latency(lat);
    check_eq("cts_latency", lat, 2);
    repeat (3 * DIV) @(negedge clk);
    cts_n = 1'b1;
    push_byte(8'h77, 1'b0, 1'b0);
    wait_idle();
    count_active(60, act);
    check_eq("cts_block", act, 0);
    begin
      exp_t e;
      e.data = 8'h77;
      e.pe   = 1'b0;
      e.po   = parity_odd;
      sb.push_back(e);
    end
    cts_n = 1'b0;
    wait_idle();
    check_eq("irq_cts", irq_cnt - i0, 2);

    // parity_en toggled mid-frame
    i0 = irq_cnt;
    s0 = starts.size();
    parity_en = 1'b0;
    push_byte(8'h5A, 1'b1, 1'b0);
    push_byte(8'hC3, 1'b1, 1'b1);
    repeat (3 * DIV) @(negedge clk);
    parity_en = 1'b1;
    wait_idle();
    if (starts.size() >= s0 + 2)
      check_eq("cfg_gap", starts[s0+1] - starts[s0], 10 * DIV);
    check_eq("irq_cfg", irq_cnt - i0, 2);
    parity_en = 1'b0;

    // reset mid-frame with bytes queued
    mon_on = 1'b0;
    push_byte(8'h81, 1'b0, 1'b0);
    push_byte(8'h82, 1'b0, 1'b0);
    push_byte(8'h83, 1'b0, 1'b0);
    repeat (3 * DIV) @(negedge clk);
    check_eq("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_tx", tx, 1);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", in_ready, 1);
    rst = 1'b0;
    count_active(80, act);
    check_eq("post_rst_idle", act, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
